// File: rtl/cdr_cal_pkg.sv
`timescale 1ns/1ps
// Shared types and default constants for the CDR VCO coarse-band calibration.
package cdr_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DECIDE,
        DONE
    } cal_state_t;

    localparam int         CAL_TUNE_W     = 5;
    localparam int         CAL_CNT_W      = 16;
    localparam int         CAL_WIN_CYC    = 1024;
    localparam int         CAL_SETTLE_CYC = 64;
    localparam logic [4:0] CAL_TUNE_RST   = 5'b01111;

endpackage

// File: rtl/vco_edge_counter.sv
`timescale 1ns/1ps
// Brings the divided VCO clock into the refclk domain, detects its rising
// edges and accumulates them in a saturating counter while enabled.
module vco_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             vco_div,
    output logic [CNT_W-1:0] cnt
);

    // [1:0] form the synchronizer, [2] holds the previous synchronized level.
    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sync_d = {sync_q[1:0], vco_div};
        rise   = sync_q[1] & ~sync_q[2];
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && rise && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vco_band_cal.sv
`timescale 1ns/1ps
// Coarse-band SAR calibration: measures VCO edges per reference window and
// binary-searches the tune code whose edge count does not exceed the target.
module vco_band_cal
    import cdr_cal_pkg::*;
#(
    parameter int                TUNE_W     = CAL_TUNE_W,
    parameter int                CNT_W      = CAL_CNT_W,
    parameter int                WIN_CYC    = CAL_WIN_CYC,
    parameter int                SETTLE_CYC = CAL_SETTLE_CYC,
    parameter logic [TUNE_W-1:0] TUNE_RST   = TUNE_W'(CAL_TUNE_RST)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              start,
    input  logic              vco_div,
    input  logic [CNT_W-1:0]  tgt_cnt,
    output logic [TUNE_W-1:0] tune,
    output logic              hold_mid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  meas_cnt
);

    localparam int                MAX_CYC     = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int                CYC_W       = $clog2(MAX_CYC + 1);
    localparam int                IDX_W       = (TUNE_W > 1) ? $clog2(TUNE_W) : 1;
    localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0]  WIN_LAST    = CYC_W'(WIN_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_MSB     = IDX_W'(TUNE_W - 1);
    localparam logic [TUNE_W-1:0] TUNE_MSB    = TUNE_W'(1) << (TUNE_W - 1);

    cal_state_t        state_q, state_d;
    logic              start_q, start_d;
    logic [CNT_W-1:0]  tgt_q, tgt_d;
    logic [TUNE_W-1:0] tune_q, tune_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              busy_q, busy_d;
    logic              hold_mid_q, hold_mid_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  meas_cnt_q, meas_cnt_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [CNT_W-1:0]  edge_cnt;

    vco_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .refclk  (refclk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .vco_div (vco_div),
        .cnt     (edge_cnt)
    );

    always_comb begin
        state_d    = state_q;
        start_d    = start && (state_q == IDLE);
        tgt_d      = tgt_q;
        tune_d     = tune_q;
        idx_d      = idx_q;
        cyc_d      = cyc_q + CYC_W'(1);
        meas_cnt_d = meas_cnt_q;
        cnt_clr    = 1'b0;
        cnt_en     = (state_q == MEASURE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d = tgt_cnt;
                end
                // The start request is registered once, so the trial begins the cycle after it is seen.
                if (start_q) begin
                    state_d = SETTLE;
                    tune_d  = TUNE_MSB;
                    idx_d   = IDX_MSB;
                    cyc_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
            SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    state_d = MEASURE;
                    cyc_d   = '0;
                end
            end
            MEASURE: begin
                if (cyc_q == WIN_LAST) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                meas_cnt_d = edge_cnt;
                if (edge_cnt > tgt_q) begin
                    tune_d[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    tune_d[idx_q - IDX_W'(1)] = 1'b1;
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = SETTLE;
                    cyc_d   = '0;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == DECIDE);
        hold_mid_d = busy_d;
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            tgt_q      <= '0;
            tune_q     <= TUNE_RST;
            idx_q      <= '0;
            cyc_q      <= '0;
            busy_q     <= 1'b0;
            hold_mid_q <= 1'b0;
            done_q     <= 1'b0;
            meas_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            tgt_q      <= tgt_d;
            tune_q     <= tune_d;
            idx_q      <= idx_d;
            cyc_q      <= cyc_d;
            busy_q     <= busy_d;
            hold_mid_q <= hold_mid_d;
            done_q     <= done_d;
            meas_cnt_q <= meas_cnt_d;
        end
    end

    assign tune     = tune_q;
    assign hold_mid = hold_mid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign meas_cnt = meas_cnt_q;

endmodule
